// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester ports, the shared ALU connection and the result port.
// The arbiter uses the slave view; the requesters, ALU and consumer use the master view.
interface alu_arbiter_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [2:0]  req0_op;
   logic        req0_alt;
   logic [31:0] req0_ra;
   logic [31:0] req0_rb;
   logic        req1_valid;
   logic        req1_ready;
   logic [2:0]  req1_op;
   logic        req1_alt;
   logic [31:0] req1_ra;
   logic [31:0] req1_rb;
   logic        alu_en;
   logic [2:0]  alu_op;
   logic        alu_alt;
   logic [31:0] alu_ra;
   logic [31:0] alu_rb;
   logic [31:0] alu_out;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [31:0] rsp_data;

   modport slave (
      input  req0_valid, req0_op, req0_alt, req0_ra, req0_rb,
      input  req1_valid, req1_op, req1_alt, req1_ra, req1_rb,
      input  alu_out, rsp_ready,
      output req0_ready, req1_ready,
      output alu_en, alu_op, alu_alt, alu_ra, alu_rb,
      output rsp_valid, rsp_id, rsp_data
   );

   modport master (
      output req0_valid, req0_op, req0_alt, req0_ra, req0_rb,
      output req1_valid, req1_op, req1_alt, req1_ra, req1_rb,
      output alu_out, rsp_ready,
      input  req0_ready, req1_ready,
      input  alu_en, alu_op, alu_alt, alu_ra, alu_rb,
      input  rsp_valid, rsp_id, rsp_data
   );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter sharing one combinational ALU: accept, issue for one cycle,
// then hold the captured result until the consumer takes it.
//
// state | meaning
// IDLE  | waiting for a request; ready offered to the granted port only
// ISSUE | alu_* driven with alu_en=1 for one cycle; result captured at its end
// RESP  | rsp_valid held with stable id/data until rsp_ready
module alu_arbiter #(
   parameter bit FIXED_PRI = 1'b0
) (
   input logic        clk,
   input logic        rst_n,
   alu_arbiter_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t      state;
   state_t      state_nxt;
   logic        rr_ptr;
   logic        sel1;
   logic        accept;
   logic        alu_en;
   logic [2:0]  alu_op;
   logic        alu_alt;
   logic [31:0] alu_ra;
   logic [31:0] alu_rb;
   logic        rsp_valid;
   logic        rsp_id;
   logic [31:0] rsp_data;

   assign bus.alu_en    = alu_en;
   assign bus.alu_op    = alu_op;
   assign bus.alu_alt   = alu_alt;
   assign bus.alu_ra    = alu_ra;
   assign bus.alu_rb    = alu_rb;
   assign bus.rsp_valid = rsp_valid;
   assign bus.rsp_id    = rsp_id;
   assign bus.rsp_data  = rsp_data;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Port 1 wins when it is alone, or when both ask and round-robin favours it.
   always_comb begin
      sel1           = 1'b0;
      accept         = 1'b0;
      bus.req0_ready = 1'b0;
      bus.req1_ready = 1'b0;
      state_nxt      = state;
      sel1 = bus.req1_valid & (~bus.req0_valid | ((FIXED_PRI == 1'b0) & rr_ptr));
      unique case (state)
         IDLE: begin
            bus.req0_ready = bus.req0_valid & ~sel1;
            bus.req1_ready = bus.req1_valid & sel1;
            accept         = bus.req0_valid | bus.req1_valid;
            if (accept) state_nxt = ISSUE;
         end
         ISSUE: state_nxt = RESP;
         RESP: if (bus.rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rr_ptr    <= 1'b0;
         alu_en    <= 1'b0;
         alu_op    <= 3'd0;
         alu_alt   <= 1'b0;
         alu_ra    <= 32'd0;
         alu_rb    <= 32'd0;
         rsp_valid <= 1'b0;
         rsp_id    <= 1'b0;
         rsp_data  <= 32'd0;
      end else begin
         unique case (state)
            IDLE: begin
               if (accept) begin
                  alu_op  <= sel1 ? bus.req1_op  : bus.req0_op;
                  alu_alt <= sel1 ? bus.req1_alt : bus.req0_alt;
                  alu_ra  <= sel1 ? bus.req1_ra  : bus.req0_ra;
                  alu_rb  <= sel1 ? bus.req1_rb  : bus.req0_rb;
                  rsp_id  <= sel1;
                  alu_en  <= 1'b1;
                  rr_ptr  <= ~rr_ptr;
               end
            end
            ISSUE: begin
               rsp_data  <= bus.alu_out;
               rsp_valid <= 1'b1;
               alu_en    <= 1'b0;
            end
            RESP: if (bus.rsp_ready) rsp_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a reference ALU feeds alu_out, and a scoreboard
// queues the expected result at each handshake and compares it on each response.
module tb_alu_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   alu_arbiter_if bus_a ();
   alu_arbiter_if bus_b ();

   alu_arbiter #(.FIXED_PRI(1'b0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a.slave));
   alu_arbiter #(.FIXED_PRI(1'b1)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b.slave));

   int checks = 0;
   int errors = 0;
   logic [32:0] sb[$];
   logic [32:0] rsp_log[$];
   bit          grants[$];

   function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic alt,
                                           input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      case (op)
         3'd0: r = alt ? a - b : a + b;
         3'd1: r = a << b[4:0];
         3'd2: r = {31'd0, $signed(a) < $signed(b)};
         3'd3: r = {31'd0, a < b};
         3'd4: r = a ^ b;
         3'd5: r = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
         3'd6: r = a | b;
         default: r = a & b;
      endcase
      return r;
   endfunction

   assign bus_a.alu_out = alu_ref(bus_a.alu_op, bus_a.alu_alt, bus_a.alu_ra, bus_a.alu_rb);
   assign bus_b.alu_out = alu_ref(bus_b.alu_op, bus_b.alu_alt, bus_b.alu_ra, bus_b.alu_rb);

   logic [104:0] outs_a;
   assign outs_a = {bus_a.req0_ready, bus_a.req1_ready, bus_a.alu_en, bus_a.alu_op,
                    bus_a.alu_alt, bus_a.alu_ra, bus_a.alu_rb, bus_a.rsp_valid,
                    bus_a.rsp_id, bus_a.rsp_data};

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Handshakes and responses are sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
      end else begin
         if (bus_a.req0_valid && bus_a.req0_ready) begin
            sb.push_back({1'b0, alu_ref(bus_a.req0_op, bus_a.req0_alt, bus_a.req0_ra, bus_a.req0_rb)});
            grants.push_back(1'b0);
         end
         if (bus_a.req1_valid && bus_a.req1_ready) begin
            sb.push_back({1'b1, alu_ref(bus_a.req1_op, bus_a.req1_alt, bus_a.req1_ra, bus_a.req1_rb)});
            grants.push_back(1'b1);
         end
         if (bus_a.rsp_valid && bus_a.rsp_ready) begin
            rsp_log.push_back({bus_a.rsp_id, bus_a.rsp_data});
            chk("sb_nonempty", 128'(sb.size() != 0), 128'd1);
            if (sb.size() != 0) chk("sb_rsp", {bus_a.rsp_id, bus_a.rsp_data}, sb.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_reqs();
      bus_a.req0_valid = 0; bus_a.req0_op = 0; bus_a.req0_alt = 0; bus_a.req0_ra = 0; bus_a.req0_rb = 0;
      bus_a.req1_valid = 0; bus_a.req1_op = 0; bus_a.req1_alt = 0; bus_a.req1_ra = 0; bus_a.req1_rb = 0;
      bus_b.req0_valid = 0; bus_b.req0_op = 0; bus_b.req0_alt = 0; bus_b.req0_ra = 0; bus_b.req0_rb = 0;
      bus_b.req1_valid = 0; bus_b.req1_op = 0; bus_b.req1_alt = 0; bus_b.req1_ra = 0; bus_b.req1_rb = 0;
   endtask

   task automatic drive0(input logic [2:0] op, input logic alt, input logic [31:0] a, input logic [31:0] b);
      bus_a.req0_op = op; bus_a.req0_alt = alt; bus_a.req0_ra = a; bus_a.req0_rb = b; bus_a.req0_valid = 1;
   endtask

   task automatic drive1(input logic [2:0] op, input logic alt, input logic [31:0] a, input logic [31:0] b);
      bus_a.req1_op = op; bus_a.req1_alt = alt; bus_a.req1_ra = a; bus_a.req1_rb = b; bus_a.req1_valid = 1;
   endtask

   task automatic wait_rsp_valid(input string tag);
      bit seen = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus_a.rsp_valid) begin seen = 1; break; end
         step();
      end
      chk(tag, 128'(seen), 128'd1);
   endtask

   task automatic drain(input string tag);
      bit ok = 0;
      for (int i = 0; i < 30; i++) begin
         if (sb.size() == 0 && !bus_a.rsp_valid && !bus_a.alu_en) begin ok = 1; break; end
         step();
      end
      chk(tag, 128'(ok), 128'd1);
   endtask

   initial begin
      int g0;
      int r1;
      int id1_seen;
      bit late_valid;
      clear_reqs();
      bus_a.rsp_ready = 0;
      bus_b.rsp_ready = 1;
      rst_n = 0;
      step(); step();
      chk("reset_outputs", 128'(outs_a), 128'd0);
      rst_n = 1;
      bus_a.rsp_ready = 1;
      step();

      // Single op: 5 + 7
      drive0(3'd0, 1'b0, 32'd5, 32'd7);
      #1;
      chk("t1_ready", {bus_a.req0_ready, bus_a.req1_ready}, 2'b10);
      step();
      chk("t1_issue", {bus_a.alu_en, bus_a.alu_op, bus_a.alu_alt, bus_a.alu_ra, bus_a.alu_rb, bus_a.rsp_valid},
          {1'b1, 3'd0, 1'b0, 32'd5, 32'd7, 1'b0});
      clear_reqs();
      step();
      chk("t1_resp", {bus_a.alu_en, bus_a.rsp_valid, bus_a.rsp_id, bus_a.rsp_data}, {1'b0, 1'b1, 1'b0, 32'd12});
      step();
      chk("t1_done", 128'(bus_a.rsp_valid), 128'd0);
      chk("t1_log", {rsp_log.size() == 1, rsp_log[0]}, {1'b1, 1'b0, 32'd12});

      // Simultaneous requests, round-robin from a fresh pointer
      rst_n = 0; step(); rst_n = 1; step();
      grants.delete(); rsp_log.delete();
      drive0(3'd0, 1'b1, 32'd10, 32'd3);
      drive1(3'd4, 1'b0, 32'hF0, 32'h0F);
      for (int i = 0; i < 30 && grants.size() < 3; i++) step();
      clear_reqs();
      chk("t2_grant_cnt", 128'(grants.size()), 128'd3);
      chk("t2_grants", {grants[0], grants[1], grants[2]}, 3'b010);
      drain("t2_drain");
      chk("t2_rsp0", rsp_log[0], {1'b0, 32'd7});
      chk("t2_rsp1", rsp_log[1], {1'b1, 32'hFF});
      chk("t2_rsp2", rsp_log[2], {1'b0, 32'd7});

      // Fixed priority: port 0 always wins
      bus_b.req0_op = 3'd6; bus_b.req0_ra = 32'h1; bus_b.req0_rb = 32'h2; bus_b.req0_valid = 1;
      bus_b.req1_op = 3'd7; bus_b.req1_ra = 32'h3; bus_b.req1_rb = 32'h1; bus_b.req1_valid = 1;
      g0 = 0; r1 = 0; id1_seen = 0;
      #1;
      for (int i = 0; i < 30; i++) begin
         if (bus_b.req0_ready) g0++;
         if (bus_b.req1_ready) r1++;
         if (bus_b.rsp_valid && bus_b.rsp_id) id1_seen++;
         if (g0 == 3) break;
         step();
      end
      clear_reqs();
      chk("t3_port0_grants", 128'(g0), 128'd3);
      chk("t3_port1_ready", 128'(r1 + id1_seen), 128'd0);
      step(); step(); step();

      // Backpressure
      rsp_log.delete();
      bus_a.rsp_ready = 0;
      drive1(3'd4, 1'b0, 32'd1, 32'd2);
      #1;
      chk("t4_accept1", {bus_a.req0_ready, bus_a.req1_ready}, 2'b01);
      step();
      clear_reqs();
      drive0(3'd6, 1'b0, 32'h30, 32'h0C);
      wait_rsp_valid("t4_rsp_timeout");
      for (int i = 0; i < 5; i++) begin
         chk("t4_hold", {bus_a.rsp_valid, bus_a.rsp_id, bus_a.rsp_data, bus_a.req0_ready, bus_a.req1_ready},
             {1'b1, 1'b1, 32'd3, 1'b0, 1'b0});
         step();
      end
      bus_a.rsp_ready = 1;
      step();
      chk("t4_ready_after", {bus_a.req0_ready, bus_a.rsp_valid}, 2'b10);
      step();
      chk("t4_accepted", {bus_a.alu_en, bus_a.alu_ra}, {1'b1, 32'h30});
      clear_reqs();
      drain("t4_drain");
      chk("t4_log", {rsp_log[0], rsp_log[1]}, {1'b1, 32'd3, 1'b0, 32'h3C});

      // Reset during ISSUE
      drive1(3'd0, 1'b0, 32'd1, 32'd1);
      step();
      chk("t5a_issue", 128'(bus_a.alu_en), 128'd1);
      clear_reqs();
      rst_n = 0;
      step();
      chk("t5a_reset_outputs", 128'(outs_a), 128'd0);
      rst_n = 1;
      step();

      // Reset during RESP; pointer must return to port 0
      bus_a.rsp_ready = 0;
      drive0(3'd7, 1'b0, 32'hFF, 32'h0F);
      step();
      clear_reqs();
      wait_rsp_valid("t5b_rsp_timeout");
      rst_n = 0;
      step();
      chk("t5b_reset_outputs", 128'(outs_a), 128'd0);
      rst_n = 1;
      bus_a.rsp_ready = 1;
      late_valid = 0;
      for (int i = 0; i < 4; i++) begin
         if (bus_a.rsp_valid) late_valid = 1;
         step();
      end
      chk("t5b_no_stale_rsp", 128'(late_valid), 128'd0);
      drive0(3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1);
      drive1(3'd3, 1'b0, 32'hFFFF_FFFF, 32'd1);
      #1;
      chk("t5b_ptr_port0", {bus_a.req0_ready, bus_a.req1_ready}, 2'b10);
      step();
      clear_reqs();
      drain("t5b_drain");

      // Arithmetic shift right via alt
      rsp_log.delete();
      drive1(3'd5, 1'b1, 32'h8000_0000, 32'd4);
      #1;
      chk("t6_ready", 128'(bus_a.req1_ready), 128'd1);
      step();
      chk("t6_issue", {bus_a.alu_en, bus_a.alu_op, bus_a.alu_alt, bus_a.alu_ra, bus_a.alu_rb},
          {1'b1, 3'd5, 1'b1, 32'h8000_0000, 32'd4});
      clear_reqs();
      drain("t6_drain");
      chk("t6_rsp", {rsp_log.size() == 1, rsp_log[0]}, {1'b1, 1'b1, 32'hF800_0000});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
